// File: rtl/bridge_arb_pkg.sv
// Shared types and widths for the bridge command-port arbiter.
package bridge_arb_pkg;
  localparam int ADDR_W      = 8;
  localparam int DATA_W      = 32;
  localparam int DEF_TIMEOUT = 256;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_e;

  typedef struct packed {
    logic              r_wb;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_w;
  } cmd_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first asserted request searching upward from last_grant+1, wrapping.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      grant_idx,
  output logic               any
);
  logic [IW:0]   j;
  logic [IW-1:0] jj;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    j         = '0;
    jj        = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = {1'b0, last_grant} + (IW+1)'(k);
      if (j >= (IW+1)'(NUM_REQ)) j = j - (IW+1)'(NUM_REQ);
      jj = j[IW-1:0];
      if (!any && req[jj]) begin
        any       = 1'b1;
        grant[jj] = 1'b1;
        grant_idx = jj;
      end
    end
  end
endmodule

// File: rtl/bridge_arbiter.sv
// Shares one bridge command port among NUM_REQ requesters; one transaction in flight.
module bridge_arbiter
  import bridge_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_r_wb,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] req_data_w,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             resp_valid,
  output logic [DATA_W-1:0]              resp_data,
  output logic                           resp_err,
  output logic                           C_in_valid,
  output logic                           C_r_wb,
  output logic [ADDR_W-1:0]              C_addr,
  output logic [DATA_W-1:0]              C_data_w,
  input  logic                           C_out_valid,
  input  logic [DATA_W-1:0]              C_data_r,
  output logic                           stray_seen
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT);

  arb_state_e state, state_nxt;

  logic [IW-1:0]      last_grant, last_d;
  logic [IW-1:0]      grant_q, grant_d;
  logic [CW-1:0]      cnt, cnt_d;
  logic [NUM_REQ-1:0] arb_grant;
  logic [IW-1:0]      arb_idx;
  logic               arb_any;
  logic               timeout;

  cmd_t               cmd_q, cmd_d;
  logic               cin_d;
  logic [NUM_REQ-1:0] ready_d, rv_d;
  logic [DATA_W-1:0]  rdata_d;
  logic               rerr_d, stray_d;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (arb_grant),
    .grant_idx  (arb_idx),
    .any        (arb_any)
  );

  assign timeout  = (cnt == CW'(TIMEOUT-1));
  assign C_r_wb   = cmd_q.r_wb;
  assign C_addr   = cmd_q.addr;
  assign C_data_w = cmd_q.data_w;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ARB_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE:  if (arb_any) state_nxt = ARB_ISSUE;
      ARB_ISSUE: state_nxt = ARB_WAIT;
      ARB_WAIT:  if (C_out_valid || timeout) state_nxt = ARB_RESP;
      ARB_RESP:  state_nxt = ARB_IDLE;
      default:   state_nxt = ARB_IDLE;
    endcase
  end

  // Next values for the output registers; command/pulse outputs default to 0,
  // response fields default to hold.
  always_comb begin
    cmd_d   = '0;
    cin_d   = 1'b0;
    ready_d = '0;
    rv_d    = '0;
    rdata_d = resp_data;
    rerr_d  = resp_err;
    stray_d = stray_seen | (C_out_valid && state != ARB_WAIT);
    last_d  = last_grant;
    grant_d = grant_q;
    cnt_d   = '0;
    case (state)
      ARB_IDLE: if (arb_any) begin
        grant_d = arb_idx;
        ready_d = arb_grant;
        cin_d   = 1'b1;
        cmd_d   = '{r_wb: req_r_wb[arb_idx], addr: req_addr[arb_idx], data_w: req_data_w[arb_idx]};
      end
      ARB_WAIT: begin
        cnt_d = cnt + 1'b1;
        if (C_out_valid) begin
          rv_d[grant_q] = 1'b1;
          rdata_d       = C_data_r;
          rerr_d        = 1'b0;
        end else if (timeout) begin
          rv_d[grant_q] = 1'b1;
          rdata_d       = '0;
          rerr_d        = 1'b1;
        end
      end
      ARB_RESP: last_d = grant_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_q      <= '0;
      C_in_valid <= 1'b0;
      req_ready  <= '0;
      resp_valid <= '0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
      stray_seen <= 1'b0;
      last_grant <= IW'(NUM_REQ-1);
      grant_q    <= '0;
      cnt        <= '0;
    end else begin
      cmd_q      <= cmd_d;
      C_in_valid <= cin_d;
      req_ready  <= ready_d;
      resp_valid <= rv_d;
      resp_data  <= rdata_d;
      resp_err   <= rerr_d;
      stray_seen <= stray_d;
      last_grant <= last_d;
      grant_q    <= grant_d;
      cnt        <= cnt_d;
    end
  end
endmodule

// File: tb/tb_bridge_arbiter.sv
// Bench for bridge_arbiter: directed scenarios with literal expectations plus
// randomized traffic compared each cycle against a transaction-level model.
module tb_bridge_arbiter;
  localparam int NR = 4;
  localparam int TO = 8;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NR-1:0]        req_valid = '0;
  logic [NR-1:0]        req_r_wb = '0;
  logic [NR-1:0][7:0]   req_addr = '0;
  logic [NR-1:0][31:0]  req_data_w = '0;
  logic [NR-1:0]        req_ready, resp_valid;
  logic [31:0]          resp_data;
  logic                 resp_err, C_in_valid, C_r_wb, stray_seen;
  logic [7:0]           C_addr;
  logic [31:0]          C_data_w;
  logic                 C_out_valid = 1'b0;
  logic [31:0]          C_data_r = '0;

  int checks = 0;
  int failures = 0;

  bridge_arbiter #(.NUM_REQ(NR), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_r_wb(req_r_wb),
    .req_addr(req_addr), .req_data_w(req_data_w), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .C_in_valid(C_in_valid), .C_r_wb(C_r_wb), .C_addr(C_addr), .C_data_w(C_data_w),
    .C_out_valid(C_out_valid), .C_data_r(C_data_r), .stray_seen(stray_seen)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: a transaction is granted, issued for one cycle,
  // waits up to TO cycles for the bridge, then answers for one cycle.
  logic [NR-1:0] e_ready, e_rv;
  logic [31:0]   e_rdata, e_dw;
  logic [7:0]    e_addr;
  logic          e_err, e_cin, e_rwb, e_stray;
  logic [1:0]    m_grant, m_last;
  bit            m_issue, m_wait, m_resp;
  int            m_waited;

  task automatic model_step();
    bit         found;
    logic [1:0] jj;
    if (rst) begin
      {e_ready, e_rv, e_rdata, e_dw, e_addr, e_err, e_cin, e_rwb, e_stray} = '0;
      m_last = 2'(NR-1); m_grant = '0;
      m_issue = 0; m_wait = 0; m_resp = 0; m_waited = 0;
      return;
    end
    e_ready = '0; e_rv = '0; e_cin = 0; e_rwb = 0; e_addr = '0; e_dw = '0;
    if (C_out_valid && !m_wait) e_stray = 1'b1;
    if (m_resp) begin
      m_last = m_grant; m_resp = 0;
    end else if (m_wait) begin
      if (C_out_valid || m_waited == TO-1) begin
        e_rv = '0; e_rv[m_grant] = 1'b1;
        e_rdata = C_out_valid ? C_data_r : 32'h0;
        e_err = !C_out_valid;
        m_wait = 0; m_resp = 1;
      end else m_waited++;
    end else if (m_issue) begin
      m_issue = 0; m_wait = 1; m_waited = 0;
    end else begin
      found = 0; jj = '0;
      for (int k = 1; k <= NR; k++) begin
        jj = 2'((int'(m_last) + k) % NR);
        if (!found && req_valid[jj]) begin found = 1; m_grant = jj; end
      end
      if (found) begin
        e_ready[m_grant] = 1'b1;
        e_cin = 1; e_rwb = req_r_wb[m_grant];
        e_addr = req_addr[m_grant]; e_dw = req_data_w[m_grant];
        m_issue = 1;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #2;
      chk("m_req_ready", 32'(req_ready), 32'(e_ready));
      chk("m_resp_valid", 32'(resp_valid), 32'(e_rv));
      chk("m_resp_data", resp_data, e_rdata);
      chk("m_resp_err", 32'(resp_err), 32'(e_err));
      chk("m_c_in_valid", 32'(C_in_valid), 32'(e_cin));
      chk("m_c_r_wb", 32'(C_r_wb), 32'(e_rwb));
      chk("m_c_addr", 32'(C_addr), 32'(e_addr));
      chk("m_c_data_w", C_data_w, e_dw);
      chk("m_stray", 32'(stray_seen), 32'(e_stray));
    end
  end

  task automatic tick(); @(negedge clk); endtask

  task automatic wait_cin(output int n);
    n = 0;
    do begin tick(); n++; end while (!C_in_valid && n < 20);
    if (!C_in_valid) begin
      checks++; failures++;
      $display("FAIL wait_c_in_valid: got none expected pulse within 20 cycles");
    end
  endtask

  task automatic wait_resp(output int n);
    n = 0;
    do begin tick(); n++; end while (resp_valid == '0 && n < 40);
    if (resp_valid == '0) begin
      checks++; failures++;
      $display("FAIL wait_resp_valid: got none expected pulse within 40 cycles");
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, 32'({req_ready, resp_valid, resp_err, C_in_valid, C_r_wb, C_addr, stray_seen}), 32'h0);
    chk({tag, "_rdata"}, resp_data, 32'h0);
    chk({tag, "_cdata"}, C_data_w, 32'h0);
  endtask

  // One complete transaction with the bridge answering in the first WAIT cycle.
  task automatic respond_first_wait(input logic [31:0] d);
    tick(); C_out_valid = 1; C_data_r = d;
    tick(); C_out_valid = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500us");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, bcnt;
    logic [NR-1:0] seen;
    tick(); tick();
    chk_zero("reset");
    rst = 0;
    tick();

    // single read from requester 2
    req_valid = 4'b0100; req_r_wb[2] = 1; req_addr[2] = 8'h15;
    wait_cin(n);
    chk("read_issue_latency", n, 1);
    chk("read_c_addr", 32'(C_addr), 32'h15);
    chk("read_c_r_wb", 32'(C_r_wb), 32'h1);
    chk("read_req_ready", 32'(req_ready), 32'h4);
    req_valid = '0;
    respond_first_wait(32'hDEAD_BEEF);
    chk("read_resp_valid", 32'(resp_valid), 32'h4);
    chk("read_resp_data", resp_data, 32'hDEAD_BEEF);
    chk("read_resp_err", 32'(resp_err), 32'h0);
    tick();
    chk("read_resp_hold", resp_data, 32'hDEAD_BEEF);

    // write from requester 1
    req_valid = 4'b0010; req_r_wb[1] = 0; req_addr[1] = 8'h3C; req_data_w[1] = 32'h1234_5678;
    wait_cin(n);
    chk("write_c_r_wb", 32'(C_r_wb), 32'h0);
    chk("write_c_data_w", C_data_w, 32'h1234_5678);
    chk("write_req_ready", 32'(req_ready), 32'h2);
    req_valid = '0;
    respond_first_wait(32'h0);
    chk("write_resp_valid", 32'(resp_valid), 32'h2);
    chk("write_resp_data", resp_data, 32'h0);

    // fairness after reset: all four held high
    tick(); rst = 1; tick(); rst = 0;
    req_valid = 4'hF;
    for (int g = 0; g < 5; g++) begin
      wait_cin(n);
      chk("fair_onehot", $countones(req_ready), 1);
      chk("fair_order", 32'(req_ready), 32'(1) << (g % NR));
      respond_first_wait(32'(g));
      chk("fair_ready_one_cycle", 32'(req_ready), 32'h0);
      if (g == 4) req_valid = '0;
    end

    // bridge answers on the last WAIT cycle: data wins over timeout
    tick();
    req_valid = 4'b0001;
    wait_cin(n);
    req_valid = '0;
    for (int i = 0; i < TO; i++) tick();
    C_out_valid = 1; C_data_r = 32'hCAFE_F00D;
    tick(); C_out_valid = 0;
    chk("race_resp_valid", 32'(resp_valid), 32'h1);
    chk("race_resp_err", 32'(resp_err), 32'h0);
    chk("race_resp_data", resp_data, 32'hCAFE_F00D);
    chk("race_no_stray", 32'(stray_seen), 32'h0);

    // timeout, then a late completion
    tick();
    req_valid = 4'b0001;
    wait_cin(n);
    req_valid = '0;
    wait_resp(n);
    chk("timeout_latency", n, TO + 1);
    chk("timeout_resp_valid", 32'(resp_valid), 32'h1);
    chk("timeout_resp_err", 32'(resp_err), 32'h1);
    chk("timeout_resp_data", resp_data, 32'h0);
    tick();
    C_out_valid = 1; C_data_r = 32'h55AA_55AA;
    tick(); C_out_valid = 0;
    seen = '0;
    for (int i = 0; i < 4; i++) begin seen |= resp_valid; tick(); end
    chk("late_stray_seen", 32'(stray_seen), 32'h1);
    chk("late_no_resp", 32'(seen), 32'h0);
    chk("late_data_kept", resp_data, 32'h0);

    // reset in the middle of WAIT aborts the transaction
    req_valid = 4'b0100;
    wait_cin(n);
    req_valid = '0;
    tick(); tick();
    rst = 1; #1;
    chk_zero("midwait_reset");
    tick(); rst = 0;
    seen = '0;
    for (int i = 0; i < 12; i++) begin seen |= resp_valid; tick(); end
    chk("midwait_no_resp", 32'(seen), 32'h0);
    req_valid = 4'b1000;
    wait_cin(n);
    chk("after_reset_grant3", 32'(req_ready), 32'h8);
    req_valid = '0;
    respond_first_wait(32'h0BAD_F00D);
    chk("after_reset_resp", 32'(resp_valid), 32'h8);

    // randomized traffic, checked by the model process
    bcnt = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      tick();
      for (int i = 0; i < NR; i++) begin
        if (req_valid[2'(i)] && req_ready[2'(i)]) req_valid[2'(i)] = 0;
        else if (!req_valid[2'(i)] && $urandom_range(0, 3) == 0) begin
          req_valid[2'(i)]  = 1;
          req_r_wb[2'(i)]   = 1'($urandom);
          req_addr[2'(i)]   = 8'($urandom);
          req_data_w[2'(i)] = $urandom;
        end
      end
      C_out_valid = 0;
      if (bcnt > 0) begin
        bcnt--;
        if (bcnt == 0) begin C_out_valid = 1; C_data_r = $urandom; end
      end else if ($urandom_range(0, 60) == 0) begin
        C_out_valid = 1; C_data_r = $urandom;
      end
      if (C_in_valid && bcnt == 0) bcnt = $urandom_range(1, TO + 3);
      rst = (cyc == 700);
      if (rst) bcnt = 0;
    end
    tick();
    rst = 0; req_valid = '0; C_out_valid = 0;
    for (int i = 0; i < 20; i++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bridge_arbiter.md
BRIDGE_ARBITER -- requirements
Module: bridge_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one bridge command port (legal 2..8).
REQ-002 Parameter TIMEOUT, default 256, maximum cycles to wait for C_out_valid before an error response (legal 2..65535).
REQ-003 clk  input  1  single clock; all logic rising-edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  NUM_REQ  per-requester request; held high until its req_ready pulse.
REQ-006 req_r_wb  input  NUM_REQ  per-requester direction (1 = read, 0 = write).
REQ-007 req_addr  input  NUM_REQ x 8  per-requester word address.
REQ-008 req_data_w  input  NUM_REQ x 32  per-requester write data.
REQ-009 req_ready  output  NUM_REQ  one-hot, one-cycle acceptance pulse.
REQ-010 resp_valid  output  NUM_REQ  one-hot, one-cycle completion pulse to the granted requester.
REQ-011 resp_data  output  32  read data or write response, valid with resp_valid.
REQ-012 resp_err  output  1  timeout flag, valid with resp_valid.
REQ-013 C_in_valid, C_r_wb, C_addr[7:0], C_data_w[31:0]  output  command to bridge.
REQ-014 C_out_valid  input  1;  C_data_r  input  32  completion from bridge.
REQ-015 stray_seen  output  1  sticky: C_out_valid arrived outside WAIT.

Function
REQ-016 FSM states SHALL be ARB_IDLE, ARB_ISSUE, ARB_WAIT and ARB_RESP; only one transaction outstanding.
REQ-017 ARB_IDLE: if any req_valid, grant the first asserted index searching upward (wrapping) from last_grant+1, latch r_wb/addr/data_w, then go to ARB_ISSUE; otherwise stay.
REQ-018 ARB_ISSUE (exactly 1 cycle): C_in_valid=1 with latched fields, req_ready[grant]=1; next state ARB_WAIT.
REQ-019 ARB_WAIT: the counter increments each cycle; if C_out_valid=1, capture C_data_r, clear err, go to ARB_RESP; else if counter==TIMEOUT-1, set err, resp_data=0, go to ARB_RESP.
REQ-020 C_out_valid and timeout in the same cycle: C_out_valid wins (no error).
REQ-021 ARB_RESP (exactly 1 cycle): resp_valid[grant]=1, resp_data and resp_err driven; last_grant<=grant; next state ARB_IDLE.
REQ-022 All outputs SHALL be registered; C_* command outputs SHALL be 0 outside ARB_ISSUE, and resp_data/resp_err SHALL hold their value outside ARB_RESP.
REQ-023 Latency: request sampled at edge N -> C_in_valid and req_ready in cycle N+1; C_out_valid at edge M -> resp_valid in cycle M+1.
REQ-024 Min back-to-back spacing: a new grant is taken in the ARB_IDLE cycle following ARB_RESP (4-cycle minimum per transaction).
REQ-025 C_out_valid outside ARB_WAIT SHALL be ignored for data and SHALL set stray_seen, which is cleared only by reset.
REQ-026 req_valid changes during non-IDLE states SHALL have no effect.

Reset
REQ-027 On rst: state=ARB_IDLE, last_grant=NUM_REQ-1 (so requester 0 wins first), counter=0, and every output 0 including stray_seen.
REQ-028 rst asserted mid-transaction SHALL abort it with no resp_valid; the bridge is reset on the same rst net.

Structure
REQ-029 Package bridge_arb_pkg SHALL hold the ARB_STATE enum, the address width (8), the data width (32) and the default TIMEOUT.
REQ-030 Round-robin selection SHALL be the sub-module rr_arbiter (inputs: request vector, last_grant; output: one-hot grant plus index).

Verification
REQ-031 Single read: req_valid[2]=1, r_wb=1, addr=8'h15 -> C_in_valid with C_addr=8'h15 one cycle later; C_data_r=32'hDEAD_BEEF -> resp_valid[2], resp_data=32'hDEAD_BEEF, resp_err=0.
REQ-032 Fairness: all four req_valid held high -> grant order 0,1,2,3,0; each req_ready pulse is one-hot and one cycle.
REQ-033 Timeout: TIMEOUT=8, no C_out_valid -> resp_valid exactly 8 cycles after entering WAIT, resp_err=1, resp_data=0.
REQ-034 Race: C_out_valid on the last WAIT cycle -> resp_err=0 with the captured data; late C_out_valid after a timeout -> stray_seen=1, no extra resp_valid.
REQ-035 Reset mid-WAIT: assert rst for 1 cycle -> all outputs 0, no resp_valid; next req_valid[3] alone -> grant 3.
REQ-036 Write: req_valid[1]=1, r_wb=0, data_w=32'h1234_5678 -> C_r_wb=0, C_data_w=32'h1234_5678; C_data_r=32'h0 -> resp_valid[1], resp_data=0.
